// File: rtl/value_bias_sink_pkg.sv
// Shared types and sizing helpers for the layer-0 attention value-bias capture/replay sink.
package value_bias_sink_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } sink_state_e;

  function automatic int calcDepth(input int size0, input int size1, input int par0, input int par1);
    return (size0 * size1) / (par0 * par1);
  endfunction

  // One spare bit above the address width keeps DEPTH-1 comparisons safe for any DEPTH.
  function automatic int calcCntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int VB_SIZE_0   = 32;
  localparam int VB_SIZE_1   = 1;
  localparam int VB_PREC_0   = 16;
  localparam int VB_PREC_1   = 3;
  localparam int VB_PAR_0    = 1;
  localparam int VB_PAR_1    = 1;
  localparam int VB_DEPTH    = calcDepth(VB_SIZE_0, VB_SIZE_1, VB_PAR_0, VB_PAR_1);
  localparam int VB_CNT_W    = calcCntWidth(VB_DEPTH);

endpackage

// File: rtl/encoder_layer_0_attention_self_value_bias_ram.sv
// Simple dual-port bias store: one write port, one registered read port, no array reset.
module encoder_layer_0_attention_self_value_bias_ram #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 16,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              i_wrEn,
  input  logic [AW-1:0]     i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdEn,
  input  logic [AW-1:0]     i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdData;

  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/encoder_layer_0_attention_self_value_bias_sink.sv
// Captures one value-bias tensor from the loader, then replays it forever to the bias adder.
module encoder_layer_0_attention_self_value_bias_sink
  import value_bias_sink_pkg::*;
#(
  parameter int VALUE_BIAS_TENSOR_SIZE_DIM_0 = VB_SIZE_0,
  parameter int VALUE_BIAS_TENSOR_SIZE_DIM_1 = VB_SIZE_1,
  parameter int VALUE_BIAS_PRECISION_0       = VB_PREC_0,
  parameter int VALUE_BIAS_PRECISION_1       = VB_PREC_1,
  parameter int VALUE_BIAS_PARALLELISM_DIM_0 = VB_PAR_0,
  parameter int VALUE_BIAS_PARALLELISM_DIM_1 = VB_PAR_1,
  localparam int P = VALUE_BIAS_PARALLELISM_DIM_0 * VALUE_BIAS_PARALLELISM_DIM_1,
  localparam int W = VALUE_BIAS_PRECISION_0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [P-1:0][W-1:0]  i_data_in,
  input  logic                 i_data_in_valid,
  output logic                 o_data_in_ready,
  input  logic                 i_reload,
  output logic                 o_load_done,
  output logic [P-1:0][W-1:0]  o_data_out,
  output logic                 o_data_out_valid,
  input  logic                 i_data_out_ready
);

  localparam int DEPTH = calcDepth(VALUE_BIAS_TENSOR_SIZE_DIM_0, VALUE_BIAS_TENSOR_SIZE_DIM_1,
                                   VALUE_BIAS_PARALLELISM_DIM_0, VALUE_BIAS_PARALLELISM_DIM_1);
  localparam int CW    = calcCntWidth(DEPTH);
  localparam int AW    = CW - 1;
  localparam int BW    = P * W;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  if ((DEPTH < 2) || (VALUE_BIAS_PRECISION_1 > VALUE_BIAS_PRECISION_0) ||
      ((DEPTH == VB_DEPTH) && (CW != VB_CNT_W))) begin : g_badParams
    $error("value-bias sink: unsupported parameter combination");
  end

  sink_state_e    r_state;
  sink_state_e    w_stateNext;
  logic [CW-1:0]  r_wrCnt;
  logic [CW-1:0]  r_rdCnt;
  logic           r_inReady;
  logic           r_rdPend;
  logic [1:0]     r_skidCnt;
  logic [BW-1:0]  r_skid0;
  logic [BW-1:0]  r_skid1;
  logic [BW-1:0]  w_ramRdData;
  logic           w_accept;
  logic           w_pop;
  logic           w_issue;
  logic [1:0]     w_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (i_reload) begin
      w_stateNext = LOAD;
    end else if ((r_state == LOAD) && w_accept && (r_wrCnt == LAST)) begin
      w_stateNext = SERVE;
    end
  end

  // Reads are issued only when the skid can absorb every beat already owed to it.
  always_comb begin
    o_load_done      = (r_state == SERVE);
    o_data_in_ready  = r_inReady;
    o_data_out_valid = (r_skidCnt != 2'd0);
    o_data_out       = r_skid0;
    w_accept         = i_data_in_valid & r_inReady;
    w_pop            = o_data_out_valid & i_data_out_ready;
    w_occ            = r_skidCnt + 2'(r_rdPend) - 2'(w_pop);
    w_issue          = (r_state == SERVE) && !i_reload && (w_occ < 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inReady <= 1'b0;
      r_wrCnt   <= '0;
      r_rdCnt   <= '0;
      r_rdPend  <= 1'b0;
    end else begin
      r_inReady <= (w_stateNext == LOAD);
      r_rdPend  <= w_issue;
      if (i_reload || (w_accept && (r_wrCnt == LAST))) begin
        r_wrCnt <= '0;
      end else if (w_accept) begin
        r_wrCnt <= r_wrCnt + CW'(1);
      end
      if (i_reload) begin
        r_rdCnt <= '0;
      end else if (w_issue) begin
        r_rdCnt <= (r_rdCnt == LAST) ? '0 : r_rdCnt + CW'(1);
      end
    end
  end

  // Two-entry FIFO: r_skid0 is always the presented head, r_skid1 the prefetched follower.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skidCnt <= 2'd0;
      r_skid0   <= '0;
      r_skid1   <= '0;
    end else if (i_reload) begin
      r_skidCnt <= 2'd0;
    end else begin
      case ({w_pop, r_rdPend})
        2'b11: begin
          if (r_skidCnt == 2'd1) begin
            r_skid0 <= w_ramRdData;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= w_ramRdData;
          end
        end
        2'b10: begin
          r_skid0   <= r_skid1;
          r_skidCnt <= r_skidCnt - 2'd1;
        end
        2'b01: begin
          if (r_skidCnt == 2'd0) begin
            r_skid0 <= w_ramRdData;
          end else begin
            r_skid1 <= w_ramRdData;
          end
          r_skidCnt <= r_skidCnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  encoder_layer_0_attention_self_value_bias_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (BW),
    .AW     (AW)
  ) u_ram (
    .clk      (clk),
    .i_wrEn   (w_accept),
    .i_wrAddr (r_wrCnt[AW-1:0]),
    .i_wrData (i_data_in),
    .i_rdEn   (w_issue),
    .i_rdAddr (r_rdCnt[AW-1:0]),
    .o_rdData (w_ramRdData)
  );

endmodule

// File: tb/tb_encoder_layer_0_attention_self_value_bias_sink.sv
// Directed bench for the value-bias capture/replay sink: load, replay, stalls, reload and async reset.
module tb_encoder_layer_0_attention_self_value_bias_sink;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [0:0][15:0]  dataIn = '0;
  logic              dataInValid = 1'b0;
  logic              dataInReady;
  logic              reload = 1'b0;
  logic              loadDone;
  logic [0:0][15:0]  dataOut;
  logic              dataOutValid;
  logic              dataOutReady = 1'b0;

  int nChecks = 0;
  int nErrors = 0;

  encoder_layer_0_attention_self_value_bias_sink dut (
    .clk              (clk),
    .rst              (rst),
    .i_data_in        (dataIn),
    .i_data_in_valid  (dataInValid),
    .o_data_in_ready  (dataInReady),
    .i_reload         (reload),
    .o_load_done      (loadDone),
    .o_data_out       (dataOut),
    .o_data_out_valid (dataOutValid),
    .i_data_out_ready (dataOutReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then moves to 1ns after the next rising edge.
  task automatic applyStimulus(input bit valid, input logic [15:0] data, input bit rl, input bit outReady);
    dataInValid  = valid;
    dataIn[0]    = data;
    reload       = rl;
    dataOutReady = outReady;
    @(posedge clk);
    #1;
    dataInValid = 1'b0;
    reload      = 1'b0;
  endtask

  // Beat k carries base+k; with gaps an idle cycle precedes every beat with k%3 == 1.
  task automatic loadTensor(input logic [15:0] base, input int nBeats, input bit gaps);
    for (int k = 0; k < nBeats; k++) begin
      if (gaps && (k % 3 == 1)) begin
        applyStimulus(1'b0, 16'hDEAD, 1'b0, 1'b1);
      end
      checkOutput("in_ready_load", dataInReady, 1'b1);
      applyStimulus(1'b1, 16'(base + k), 1'b0, 1'b1);
    end
  endtask

  // Called just after the final accept edge T; ends at T+2 when beat 0 is due.
  task automatic waitServeStart();
    checkOutput("in_ready_after_last", dataInReady, 1'b0);
    checkOutput("load_done_after_last", loadDone, 1'b1);
    checkOutput("valid_T0", dataOutValid, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("valid_T1", dataOutValid, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic serveCheck(input logic [15:0] base, input int startIdx, input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput("serve_valid", dataOutValid, 1'b1);
      checkOutput("serve_data", dataOut[0], 16'(base + ((startIdx + i) % 32)));
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] readyPat;
    int idx;
    bit found;
    bit r;

    // Reset values before any clock edge
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", dataInReady, 1'b0);
    checkOutput("rst_load_done", loadDone, 1'b0);
    checkOutput("rst_out_valid", dataOutValid, 1'b0);
    checkOutput("rst_data_out", dataOut[0], 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_rst", dataInReady, 1'b1);
    checkOutput("load_done_after_rst", loadDone, 1'b0);

    // Back-to-back load of 0x0001..0x0020, then 40 beats of replay including the wrap
    $display("[TB] back-to-back load and replay");
    loadTensor(16'h0001, 32, 1'b0);
    waitServeStart();
    serveCheck(16'h0001, 0, 40);

    // Replay under a fixed stall pattern; the presented beat must hold while stalled
    $display("[TB] replay with downstream stalls");
    readyPat = 16'b1001_1101_1011_0111;
    idx = 40;
    for (int c = 0; c < 100; c++) begin
      r = readyPat[c % 16];
      dataOutReady = r;
      checkOutput("stall_valid", dataOutValid, 1'b1);
      checkOutput("stall_data", dataOut[0], 16'(1 + (idx % 32)));
      if (r) idx++;
      applyStimulus(1'b0, 16'h0, 1'b0, r);
    end

    // Reload while beat 10 (0x000B) is being handed over
    $display("[TB] reload mid-replay");
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (dataOutValid && dataOut[0] == 16'h000B) found = 1'b1;
      else applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    end
    checkOutput("find_beat10", 16'(found), 16'h0001);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("reload_valid", dataOutValid, 1'b0);
    checkOutput("reload_load_done", loadDone, 1'b0);
    checkOutput("reload_in_ready", dataInReady, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("reload_valid_2", dataOutValid, 1'b0);
    loadTensor(16'h0100, 32, 1'b0);
    waitServeStart();
    serveCheck(16'h0100, 0, 33);

    // Reload coincident with the 32nd accept keeps the sink in LOAD
    $display("[TB] reload coincident with last accept");
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("reload2_in_ready", dataInReady, 1'b1);
    loadTensor(16'h0200, 31, 1'b0);
    checkOutput("in_ready_beat31", dataInReady, 1'b1);
    applyStimulus(1'b1, 16'h021F, 1'b1, 1'b1);
    checkOutput("coinc_load_done", loadDone, 1'b0);
    checkOutput("coinc_in_ready", dataInReady, 1'b1);
    checkOutput("coinc_valid", dataOutValid, 1'b0);
    loadTensor(16'h0300, 32, 1'b1);
    waitServeStart();
    serveCheck(16'h0300, 0, 34);

    // Asynchronous reset between clock edges in the middle of a load
    $display("[TB] async reset mid-load");
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    loadTensor(16'h0400, 5, 1'b0);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_in_ready", dataInReady, 1'b0);
    checkOutput("arst_load_done", loadDone, 1'b0);
    checkOutput("arst_out_valid", dataOutValid, 1'b0);
    checkOutput("arst_data_out", dataOut[0], 16'h0000);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("arst_in_ready_release", dataInReady, 1'b1);
    checkOutput("arst_load_done_release", loadDone, 1'b0);
    loadTensor(16'h0500, 32, 1'b0);
    waitServeStart();
    serveCheck(16'h0500, 0, 33);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
